uart_rx: RTL and testbench

- Serial-to-parallel receive stage of the on-chip UART, sitting between the pad-side serial_rx line and the UART bus wrapper's receive register.
- Synchronizes the asynchronous RX line, detects the start bit, samples 8N1 frames at mid-bit, and presents each received byte on a ready/valid interface.
- Flags framing errors and overruns as one-cycle pulses for status logic.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 33 +++
 rtl/uart_sync.sv | 29 ++
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Receive-side ready/valid byte stream plus status pulses.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data_out_o;
    logic                      data_out_valid_o;
    logic                      data_out_ready_i;
    logic                      frame_err_o;
    logic                      overrun_o;

    modport master (
        output data_out_o,
        output data_out_valid_o,
        input  data_out_ready_i,
        output frame_err_o,
        output overrun_o
    );

    modport slave (
        input  data_out_o,
        input  data_out_valid_o,
        output data_out_ready_i,
        input  frame_err_o,
        input  overrun_o
    );

endinterface
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync
// Description : Two-flop synchronizer with a configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic d_i,
    output logic      q_o
);

    logic [1:0] r_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= {2{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[0], d_i};
        end
    end

    assign q_o = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with mid-bit sampling, ready/valid output,
//               framing-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  wire logic  clk_i,
    input  wire logic  rst_ni,
    input  wire logic  serial_rx_i,
    uart_rx_if.master  rx_if
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    logic                      w_rx_s;
    uart_rx_state_e            r_state,     w_state_next;
    logic [CNT_W-1:0]          r_clk_cnt,   w_clk_cnt_next;
    logic [2:0]                r_bit_cnt,   w_bit_cnt_next;
    logic [UART_DATA_BITS-1:0] r_shift,     w_shift_next;
    logic [UART_DATA_BITS-1:0] r_data,      w_data_next;
    logic                      r_valid,     w_valid_next;
    logic                      r_frame_err, w_frame_err_next;
    logic                      r_overrun,   w_overrun_next;
    logic                      w_deliver;

    uart_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (serial_rx_i),
        .q_o    (w_rx_s)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clk_cnt   <= w_clk_cnt_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_frame_err_next;
            r_overrun   <= w_overrun_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_clk_cnt_next   = r_clk_cnt;
        w_bit_cnt_next   = r_bit_cnt;
        w_shift_next     = r_shift;
        w_deliver        = 1'b0;
        w_frame_err_next = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_next   = START;
                    w_clk_cnt_next = '0;
                end
            end
            START: begin
                if (r_clk_cnt == SAMPLE_LAST) begin
                    // A line that is high again at mid-start was only a glitch
                    if (w_rx_s) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next   = DATA;
                        w_clk_cnt_next = '0;
                        w_bit_cnt_next = '0;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_clk_cnt == SYMBOL_LAST) begin
                    w_shift_next   = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                    w_clk_cnt_next = '0;
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = STOP;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_clk_cnt == SYMBOL_LAST) begin
                    w_clk_cnt_next = '0;
                    if (w_rx_s) begin
                        w_deliver    = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = WAIT_HIGH;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                // Swallow a held-low break so it reports only one error
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_data_next    = r_data;
        w_valid_next   = r_valid;
        w_overrun_next = 1'b0;

        if (w_deliver) begin
            w_data_next    = r_shift;
            w_valid_next   = 1'b1;
            w_overrun_next = r_valid && !rx_if.data_out_ready_i;
        end else if (r_valid && rx_if.data_out_ready_i) begin
            w_valid_next = 1'b0;
        end
    end

    assign rx_if.data_out_o       = r_data;
    assign rx_if.data_out_valid_o = r_valid;
    assign rx_if.frame_err_o      = r_frame_err;
    assign rx_if.overrun_o        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx using a frame-level event model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int BIT_CYC = 10;

    typedef struct packed {
        logic       is_ferr;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic serial_rx;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_ovr = 0;
    int   n_ferr = 0;
    logic ovr_allowed = 1'b0;
    exp_t exp_q[$];

    uart_rx_if rx_if ();

    uart_rx #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .serial_rx_i (serial_rx),
        .rx_if       (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        serial_rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame, LSB first; a bad stop bit may be stretched into a break.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int hold_low);
        exp_t e;
        e.is_ferr = !stop_ok;
        e.data    = d;
        exp_q.push_back(e);
        drive_bit(1'b0, BIT_CYC);
        check("drain_prev", exp_q.size(), 1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CYC);
        if (stop_ok) begin
            drive_bit(1'b1, BIT_CYC);
        end else begin
            drive_bit(1'b0, BIT_CYC + hold_low);
            drive_bit(1'b1, BIT_CYC);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"},  rx_if.data_out_o,       0);
        check({tag, "_valid"}, rx_if.data_out_valid_o, 0);
        check({tag, "_ferr"},  rx_if.frame_err_o,      0);
        check({tag, "_ovr"},   rx_if.overrun_o,        0);
    endtask

    // Monitor: every delivery (valid rise or overwrite) and every error pulse
    // must match the next expected frame outcome.
    initial begin
        logic prev_valid;
        logic expect_clear;
        exp_t e;
        prev_valid   = 1'b0;
        expect_clear = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid   = 1'b0;
                expect_clear = 1'b0;
            end else begin
                if (expect_clear) begin
                    check("valid_clear", rx_if.data_out_valid_o, 0);
                    expect_clear = 1'b0;
                end
                if ((rx_if.data_out_valid_o && !prev_valid) || rx_if.overrun_o || rx_if.frame_err_o) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_evt",
                              {29'b0, rx_if.data_out_valid_o, rx_if.frame_err_o, rx_if.overrun_o}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("evt_kind", rx_if.frame_err_o, e.is_ferr);
                        if (!e.is_ferr) check("rx_byte", rx_if.data_out_o, e.data);
                    end
                    if (rx_if.overrun_o) begin
                        n_ovr++;
                        check("overrun_allowed", rx_if.overrun_o, ovr_allowed);
                    end
                    if (rx_if.frame_err_o) n_ferr++;
                    if (rx_if.data_out_valid_o && rx_if.data_out_ready_i) expect_clear = 1'b1;
                end
                prev_valid = rx_if.data_out_valid_o;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ferr_before;
        rst_n     = 1'b0;
        serial_rx = 1'b1;
        rx_if.data_out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        drive_bit(1'b1, 5);

        // Basic frame
        send_frame(8'hA5, 1'b1, 0);
        drive_bit(1'b1, 5);
        check("a5_drained", exp_q.size(), 0);

        // Short low glitch must be rejected
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 20);
        check("glitch_no_evt", exp_q.size(), 0);

        // Bad stop bit followed by a long break, then a good frame
        ferr_before = n_ferr;
        send_frame(8'h3C, 1'b0, 30);
        drive_bit(1'b1, 5);
        check("break_one_ferr", n_ferr - ferr_before, 1);
        send_frame(8'h81, 1'b1, 0);
        drive_bit(1'b1, 5);
        check("81_drained", exp_q.size(), 0);

        // Overrun with the consumer stalled
        rx_if.data_out_ready_i = 1'b0;
        ovr_allowed = 1'b1;
        send_frame(8'h11, 1'b1, 0);
        check("ovr_first_valid", rx_if.data_out_valid_o, 1);
        check("ovr_first_data",  rx_if.data_out_o, 8'h11);
        send_frame(8'h22, 1'b1, 0);
        drive_bit(1'b1, 5);
        check("ovr_second_valid", rx_if.data_out_valid_o, 1);
        check("ovr_second_data",  rx_if.data_out_o, 8'h22);
        check("ovr_pulse_count",  n_ovr, 1);
        ovr_allowed = 1'b0;
        rx_if.data_out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("ready_clears_valid", rx_if.data_out_valid_o, 0);

        // Reset mid-frame while an unread byte is pending
        rx_if.data_out_ready_i = 1'b0;
        send_frame(8'h77, 1'b1, 0);
        check("pre_reset_valid", rx_if.data_out_valid_o, 1);
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) drive_bit(i[0], BIT_CYC);
        drive_bit(1'b1, 5);
        rst_n     = 1'b0;
        serial_rx = 1'b1;
        @(negedge clk);
        check_outputs_zero("midframe_reset");
        rx_if.data_out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_bit(1'b1, 60);
        check("no_partial_byte", exp_q.size(), 0);
        send_frame(8'h5A, 1'b1, 0);
        drive_bit(1'b1, 5);
        check("post_reset_data", rx_if.data_out_o, 8'h5A);

        // Back-to-back boundary values
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h55, 1'b1, 0);
        drive_bit(1'b1, 5);
        check("b2b_drained", exp_q.size(), 0);

        // Randomized frames, gaps, glitches and breaks
        for (int k = 0; k < 24; k++) begin
            int gap;
            gap = $urandom_range(0, 15);
            if (gap > 0) drive_bit(1'b1, gap);
            if ($urandom_range(0, 3) == 0) begin
                drive_bit(1'b0, $urandom_range(1, 3));
                drive_bit(1'b1, BIT_CYC);
            end
            send_frame(8'($urandom), ($urandom_range(0, 4) != 0), $urandom_range(0, 20));
        end
        drive_bit(1'b1, 20);
        check("random_drained", exp_q.size(), 0);
        check("random_no_overrun", n_ovr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
